// File: rtl/ppa_seq_pkg.sv
// Shared types and helpers for ppa_chunk_sequencer.
package ppa_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Chunk index width; a single-chunk build still needs a 1-bit index.
    function automatic int idx_width(input int chunks);
        return (chunks <= 1) ? 1 : $clog2(chunks);
    endfunction

endpackage

// File: rtl/ppa_chunk_sequencer.sv
// Wide adder sequencer: splits an N-bit add into CHUNKS passes through an
// external WIDTH-bit adder, LSB chunk first, chaining the carry.
// Optional macro PPA_SEQ_OVF_EN adds the out_ovf two's-complement overflow port.
//
// state | meaning
// IDLE  | waiting for an operand pair, adder inputs forced to 0
// RUN   | one chunk per cycle through the external adder
// DONE  | result presented, held until out_ready
module ppa_chunk_sequencer
    import ppa_seq_pkg::*;
#(
    parameter int WIDTH  = 7,
    parameter int CHUNKS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*CHUNKS-1:0] in_a,
    input  logic [WIDTH*CHUNKS-1:0] in_b,
    input  logic                    in_cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH*CHUNKS-1:0] out_sum,
    output logic                    out_cout,
`ifdef PPA_SEQ_OVF_EN
    output logic                    out_ovf,
`endif
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    output logic                    add_cin,
    input  logic [WIDTH-1:0]        add_s,
    input  logic                    add_cout
);

    localparam int N    = WIDTH * CHUNKS;
    localparam int IDXW = idx_width(CHUNKS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHUNKS - 1);

    seq_state_e      state_q, state_d;
    logic [IDXW-1:0] idx;
    logic            carry;
    logic [N-1:0]    a_reg, b_reg;
    logic            accept;
    logic            last_chunk;

    assign accept     = (state_q == IDLE) && in_valid;
    assign last_chunk = (idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, handshake outputs and adder operand mux.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                for (int c = 0; c < CHUNKS; c++) begin
                    if (idx == IDXW'(c)) begin
                        add_a = a_reg[c*WIDTH +: WIDTH];
                        add_b = b_reg[c*WIDTH +: WIDTH];
                    end
                end
                add_cin = carry;
                if (last_chunk) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, chunk counter, carry chain and result assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else if (accept) begin
            a_reg <= in_a;
            b_reg <= in_b;
            carry <= in_cin;
            idx   <= '0;
        end else if (state_q == RUN) begin
            for (int c = 0; c < CHUNKS; c++) begin
                if (idx == IDXW'(c)) out_sum[c*WIDTH +: WIDTH] <= add_s;
            end
            carry <= add_cout;
            if (last_chunk) begin
                out_cout <= add_cout;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef PPA_SEQ_OVF_EN
    // Signed overflow is judged from the top chunk's sum bit on the final pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ovf <= 1'b0;
        end else if (state_q == RUN && last_chunk) begin
            out_ovf <= (a_reg[N-1] == b_reg[N-1]) && (add_s[WIDTH-1] != a_reg[N-1]);
        end
    end
`endif

endmodule

// File: tb/tb_ppa_chunk_sequencer.sv
// Directed bench for ppa_chunk_sequencer with a behavioural 7-bit adder.
module tb_ppa_chunk_sequencer;

    localparam int WIDTH  = 7;
    localparam int CHUNKS = 4;
    localparam int N      = WIDTH * CHUNKS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_a = '0;
    logic [N-1:0]     in_b = '0;
    logic             in_cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     out_sum;
    logic             out_cout;
    logic [WIDTH-1:0] add_a, add_b, add_s;
    logic             add_cin, add_cout;
`ifdef PPA_SEQ_OVF_EN
    logic             out_ovf;
`endif

    int checks = 0;
    int errors = 0;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    always #5 clk = ~clk;

    ppa_chunk_sequencer #(.WIDTH(WIDTH), .CHUNKS(CHUNKS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
`ifdef PPA_SEQ_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Poll for out_valid with a cycle budget; returns cycles waited.
    task automatic wait_valid(input string tag, output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        check({tag, "_valid_seen"}, {31'b0, out_valid}, 32'd1);
    endtask

    // One full operation starting in IDLE, at #1 after a rising edge.
    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic cin, input logic [N-1:0] es, input logic ec,
                          input logic eovf, input logic chk_lat);
        int cyc;
        check({tag, "_in_ready_idle"}, {31'b0, in_ready}, 32'd1);
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_in_ready_run"}, {31'b0, in_ready}, 32'd0);
        check({tag, "_add_a_chunk0"}, {25'b0, add_a}, {25'b0, a[WIDTH-1:0]});
        check({tag, "_add_cin_chunk0"}, {31'b0, add_cin}, {31'b0, cin});
        wait_valid(tag, cyc);
        if (chk_lat) check({tag, "_latency"}, cyc, 32'd4);
        check({tag, "_sum"}, {4'b0, out_sum}, {4'b0, es});
        check({tag, "_cout"}, {31'b0, out_cout}, {31'b0, ec});
`ifdef PPA_SEQ_OVF_EN
        check({tag, "_ovf"}, {31'b0, out_ovf}, {31'b0, eovf});
`else
        if (eovf === 1'bx) $display("unused");
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_in_ready_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int cyc;
        // Reset state
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_sum", {4'b0, out_sum}, 32'd0);
        check("rst_out_cout", {31'b0, out_cout}, 32'd0);
        rst = 1'b0;
        tick();
        in_a = 28'hFFFFFFF; in_b = 28'hFFFFFFF; in_cin = 1'b1;
        #1;
        check("idle_add_a_zero", {25'b0, add_a}, 32'd0);
        check("idle_add_b_zero", {25'b0, add_b}, 32'd0);
        check("idle_add_cin_zero", {31'b0, add_cin}, 32'd0);
        tick();

        // Basic adds
        run_op("simple",  28'h0000001, 28'h0000002, 1'b0, 28'h0000003, 1'b0, 1'b0, 1'b1);
        run_op("ripple",  28'hFFFFFFF, 28'h0000001, 1'b0, 28'h0000000, 1'b1, 1'b0, 1'b1);
        run_op("chunk01", 28'h000007F, 28'h0000000, 1'b1, 28'h0000080, 1'b0, 1'b0, 1'b0);
        run_op("ovf_pos", 28'h7FFFFFF, 28'h0000001, 1'b0, 28'h8000000, 1'b0, 1'b1, 1'b0);

        // Stalled result with a second request held pending
        in_a = 28'h1234560; in_b = 28'h0000007; in_cin = 1'b0; in_valid = 1'b1;
        tick();
        in_a = 28'h0000005; in_b = 28'h0000006;
        wait_valid("stall", cyc);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_sum", {4'b0, out_sum}, 32'h1234567);
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        check("stall_sum_end", {4'b0, out_sum}, 32'h1234567);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_pending_ready", {31'b0, in_ready}, 32'd1);
        check("stall_valid_drop", {31'b0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        check("pending_accepted", {31'b0, in_ready}, 32'd0);
        wait_valid("pending", cyc);
        check("pending_sum", {4'b0, out_sum}, 32'h000000B);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of RUN at idx=2
        in_a = 28'h0001000; in_b = 28'h0002000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("midrun_add_a_idx2", {25'b0, add_a}, 32'h00);
        check("midrun_add_b_idx2", {25'b0, add_b}, 32'h00);
        check("midrun_in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("midrun_rst_valid", {31'b0, out_valid}, 32'd0);
        check("midrun_rst_ready", {31'b0, in_ready}, 32'd1);
        check("midrun_rst_sum", {4'b0, out_sum}, 32'd0);
        tick();
        run_op("after_rst", 28'h0000010, 28'h0000020, 1'b0, 28'h0000030, 1'b0, 1'b0, 1'b1);
        run_op("neg_ovf",   28'h8000000, 28'h8000000, 1'b0, 28'h0000000, 1'b1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
